// File: rtl/multdiv_issue_ctrl_pkg.sv
// Shared state encoding and exception constants for the mult/div issue controller.
// The optional watchdog in the top level is enabled by defining MULTDIV_TIMEOUT_EN.
package multdiv_issue_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DONE  = 2'd2,
    ABORT = 2'd3
  } md_state_t;

  localparam int STATUS_REG   = 30;
  localparam int MUL_EXC_CODE = 4;
  localparam int DIV_EXC_CODE = 5;

endpackage

// File: rtl/multdiv_cycle_counter.sv
// Saturating up-counter with synchronous clear; times how long the mult/div unit has run.
module multdiv_cycle_counter #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         ctrl_reset,
  input  logic         clear,
  input  logic         enable,
  output logic [W-1:0] count
);

  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset)
      count <= '0;
    else if (clear)
      count <= '0;
    else if (enable && (count != '1))
      count <= count + W'(1);
  end

endmodule

// File: rtl/multdiv_issue_ctrl.sv
// Issues MUL/DIV ops from DX to the multi-cycle unit, stalls the front end while it runs,
// and emits one writeback record per op. Define MULTDIV_TIMEOUT_EN for the watchdog.
//
// state | meaning
// IDLE  | no op in flight; accept MUL/DIV from DX
// BUSY  | unit running, front end stalled
// DONE  | writeback record valid this cycle, held instruction advances
// ABORT | op squashed by flush; wait for the stale result and drop it
module multdiv_issue_ctrl #(
  parameter int DATA_W         = 32,
  parameter int REG_BITS       = 5,
  parameter int STATUS_REG     = multdiv_issue_ctrl_pkg::STATUS_REG,
  parameter int MUL_EXC_CODE   = multdiv_issue_ctrl_pkg::MUL_EXC_CODE,
  parameter int DIV_EXC_CODE   = multdiv_issue_ctrl_pkg::DIV_EXC_CODE,
  parameter int TIMEOUT_CYCLES = 40
) (
  input  logic                clock,
  input  logic                ctrl_reset,
  input  logic                op_valid,
  input  logic                op_is_div,
  input  logic [REG_BITS-1:0] op_rd,
  input  logic [DATA_W-1:0]   op_dataA,
  input  logic [DATA_W-1:0]   op_dataB,
  input  logic                flush,
  output logic                md_ctrl_MULT,
  output logic                md_ctrl_DIV,
  output logic [DATA_W-1:0]   md_operandA,
  output logic [DATA_W-1:0]   md_operandB,
  input  logic                md_resultRDY,
  input  logic [DATA_W-1:0]   md_result,
  input  logic                md_exception,
  output logic                stall,
  output logic                wb_valid,
  output logic [REG_BITS-1:0] wb_rd,
  output logic [DATA_W-1:0]   wb_data,
  output logic                busy
);
  import multdiv_issue_ctrl_pkg::*;

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

`ifdef MULTDIV_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  md_state_t           state;
  logic                kind_div;
  logic [REG_BITS-1:0] rd_q;
  logic [CNT_W-1:0]    cycles;
  logic                issue;
  logic                timeout;
  logic [DATA_W-1:0]   exc_data;

  assign issue    = (state == IDLE) && op_valid && !flush;
  assign busy     = (state != IDLE);
  assign timeout  = TIMEOUT_ON && (cycles >= LIMIT);
  assign exc_data = kind_div ? DATA_W'(DIV_EXC_CODE) : DATA_W'(MUL_EXC_CODE);

  multdiv_cycle_counter #(.W(CNT_W)) u_cycle_counter (
    .clock      (clock),
    .ctrl_reset (ctrl_reset),
    .clear      (issue),
    .enable     ((state == BUSY) || (state == ABORT)),
    .count      (cycles)
  );

  // ABORT only holds back another mult/div; ordinary instructions keep flowing.
  always_comb begin
    stall = 1'b0;
    case (state)
      IDLE:    stall = issue;
      BUSY:    stall = 1'b1;
      ABORT:   stall = op_valid;
      default: stall = 1'b0;
    endcase
  end

  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      state        <= IDLE;
      kind_div     <= 1'b0;
      rd_q         <= '0;
      md_ctrl_MULT <= 1'b0;
      md_ctrl_DIV  <= 1'b0;
      md_operandA  <= '0;
      md_operandB  <= '0;
      wb_valid     <= 1'b0;
      wb_rd        <= '0;
      wb_data      <= '0;
    end else begin
      md_ctrl_MULT <= 1'b0;
      md_ctrl_DIV  <= 1'b0;
      wb_valid     <= 1'b0;
      case (state)
        IDLE: begin
          if (issue) begin
            state        <= BUSY;
            kind_div     <= op_is_div;
            rd_q         <= op_rd;
            md_operandA  <= op_dataA;
            md_operandB  <= op_dataB;
            md_ctrl_MULT <= !op_is_div;
            md_ctrl_DIV  <= op_is_div;
          end
        end
        BUSY: begin
          // A flush coinciding with the result still squashes it.
          if (flush) begin
            state <= md_resultRDY ? IDLE : ABORT;
          end else if (md_resultRDY && !md_exception) begin
            state    <= DONE;
            wb_valid <= 1'b1;
            wb_rd    <= rd_q;
            wb_data  <= md_result;
          end else if (md_resultRDY || timeout) begin
            state    <= DONE;
            wb_valid <= 1'b1;
            wb_rd    <= REG_BITS'(STATUS_REG);
            wb_data  <= exc_data;
          end
        end
        DONE: state <= IDLE;
        ABORT: begin
          if (md_resultRDY || timeout)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_issue_ctrl.sv
// Directed self-checking bench for multdiv_issue_ctrl; timeout scenario runs only
// when MULTDIV_TIMEOUT_EN is defined.
module tb_multdiv_issue_ctrl;

  logic        clock;
  logic        ctrl_reset;
  logic        op_valid;
  logic        op_is_div;
  logic [4:0]  op_rd;
  logic [31:0] op_dataA;
  logic [31:0] op_dataB;
  logic        flush;
  logic        md_ctrl_MULT;
  logic        md_ctrl_DIV;
  logic [31:0] md_operandA;
  logic [31:0] md_operandB;
  logic        md_resultRDY;
  logic [31:0] md_result;
  logic        md_exception;
  logic        stall;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        busy;

  int n_assert = 0;
  int n_fail   = 0;

  multdiv_issue_ctrl dut (
    .clock        (clock),
    .ctrl_reset   (ctrl_reset),
    .op_valid     (op_valid),
    .op_is_div    (op_is_div),
    .op_rd        (op_rd),
    .op_dataA     (op_dataA),
    .op_dataB     (op_dataB),
    .flush        (flush),
    .md_ctrl_MULT (md_ctrl_MULT),
    .md_ctrl_DIV  (md_ctrl_DIV),
    .md_operandA  (md_operandA),
    .md_operandB  (md_operandB),
    .md_resultRDY (md_resultRDY),
    .md_result    (md_result),
    .md_exception (md_exception),
    .stall        (stall),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .busy         (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Caller is in IDLE just after a rising edge. Returns one cycle after DONE,
  // with op_valid still asserted.
  task automatic issue_op(input string tag, input logic is_div, input logic [4:0] rd,
                          input logic [31:0] a, input logic [31:0] b, input int lat,
                          input logic exc, input logic [31:0] res,
                          input logic [4:0] exp_rd, input logic [31:0] exp_data);
    int stalls;
    int mp;
    int dp;
    op_valid  = 1'b1;
    op_is_div = is_div;
    op_rd     = rd;
    op_dataA  = a;
    op_dataB  = b;
    #1;
    check({tag, "_accept_stall"}, 32'(stall), 32'd1);
    stalls = int'(stall);
    mp = 0;
    dp = 0;
    for (int i = 1; i <= lat; i++) begin
      step();
      mp += int'(md_ctrl_MULT);
      dp += int'(md_ctrl_DIV);
      if (i == 1) begin
        check({tag, "_operandA"}, md_operandA, a);
        check({tag, "_operandB"}, md_operandB, b);
      end
      if (i == lat) begin
        md_resultRDY = 1'b1;
        md_result    = res;
        md_exception = exc;
      end
      #1;
      stalls += int'(stall);
    end
    step();
    md_resultRDY = 1'b0;
    md_exception = 1'b0;
    md_result    = '0;
    #1;
    check({tag, "_wb_valid"}, 32'(wb_valid), 32'd1);
    check({tag, "_wb_rd"}, 32'(wb_rd), 32'(exp_rd));
    check({tag, "_wb_data"}, wb_data, exp_data);
    check({tag, "_done_stall"}, 32'(stall), 32'd0);
    check({tag, "_stall_cycles"}, 32'(stalls), 32'(lat + 1));
    check({tag, "_mult_pulses"}, 32'(mp), is_div ? 32'd0 : 32'd1);
    check({tag, "_div_pulses"}, 32'(dp), is_div ? 32'd1 : 32'd0);
    step();
    check({tag, "_no_reissue"}, 32'({md_ctrl_MULT, md_ctrl_DIV}), 32'd0);
    check({tag, "_wb_one_cycle"}, 32'(wb_valid), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    ctrl_reset   = 1'b1;
    op_valid     = 1'b0;
    op_is_div    = 1'b0;
    op_rd        = '0;
    op_dataA     = '0;
    op_dataB     = '0;
    flush        = 1'b0;
    md_resultRDY = 1'b0;
    md_result    = '0;
    md_exception = 1'b0;
    step();
    step();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_ctrl", 32'({md_ctrl_MULT, md_ctrl_DIV}), 32'd0);
    check("rst_operandA", md_operandA, 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    ctrl_reset = 1'b0;
    step();

    // MUL 7x6 -> r3, unit latency 33: 34 stall cycles
    issue_op("mul7x6", 1'b0, 5'd3, 32'd7, 32'd6, 33, 1'b0, 32'd42, 5'd3, 32'd42);
    op_valid = 1'b0;
    step();

    // DIV 100/0 -> divide-by-zero code into rstatus
    issue_op("div_by0", 1'b1, 5'd9, 32'd100, 32'd0, 6, 1'b1, 32'hffff_ffff, 5'd30, 32'd5);
    op_valid = 1'b0;
    step();

    // MUL overflow -> multiply code into rstatus
    issue_op("mul_ovf", 1'b0, 5'd12, 32'h8000_0000, 32'd4, 5, 1'b1, 32'd0, 5'd30, 32'd4);
    op_valid = 1'b0;
    step();

    // rd = 0 still produces a record
    issue_op("mul_rd0", 1'b0, 5'd0, 32'h11, 32'h5, 3, 1'b0, 32'h55, 5'd0, 32'h55);
    op_valid = 1'b0;
    step();

    // back-to-back MUL then DIV
    issue_op("b2b_mul", 1'b0, 5'd1, 32'd9, 32'd9, 4, 1'b0, 32'd81, 5'd1, 32'd81);
    issue_op("b2b_div", 1'b1, 5'd2, 32'd81, 32'd9, 4, 1'b0, 32'd9, 5'd2, 32'd9);
    op_valid = 1'b0;
    step();

    // op flushed in the accept cycle is never issued
    op_valid = 1'b1; op_is_div = 1'b0; op_rd = 5'd5; op_dataA = 32'd1; op_dataB = 32'd2;
    flush = 1'b1;
    #1;
    check("idle_flush_stall", 32'(stall), 32'd0);
    step();
    check("idle_flush_busy", 32'(busy), 32'd0);
    check("idle_flush_ctrl", 32'(md_ctrl_MULT), 32'd0);
    flush = 1'b0; op_valid = 1'b0;
    step();

    // flush in BUSY cycle 5, new MUL waits in ABORT for the stale result
    op_valid = 1'b1; op_is_div = 1'b0; op_rd = 5'd4; op_dataA = 32'd2; op_dataB = 32'd9;
    #1;
    for (int i = 1; i <= 5; i++) step();
    flush = 1'b1;
    #1;
    check("flush_busy_stall", 32'(stall), 32'd1);
    step();
    flush = 1'b0; op_valid = 1'b0;
    #1;
    check("abort_stall_drop", 32'(stall), 32'd0);
    check("abort_busy", 32'(busy), 32'd1);
    check("abort_no_wb", 32'(wb_valid), 32'd0);
    op_valid = 1'b1; op_is_div = 1'b0; op_rd = 5'd6; op_dataA = 32'd3; op_dataB = 32'd5;
    #1;
    check("abort_new_op_stall", 32'(stall), 32'd1);
    step();
    step();
    #1;
    check("abort_hold_stall", 32'(stall), 32'd1);
    check("abort_no_issue", 32'(md_ctrl_MULT), 32'd0);
    md_resultRDY = 1'b1; md_result = 32'hdead;
    step();
    md_resultRDY = 1'b0; md_result = '0;
    check("abort_back_idle", 32'(busy), 32'd0);
    check("abort_discard", 32'(wb_valid), 32'd0);
    issue_op("after_abort", 1'b0, 5'd6, 32'd3, 32'd5, 4, 1'b0, 32'd15, 5'd6, 32'd15);
    op_valid = 1'b0;
    step();

    // flush and result in the same BUSY cycle: result dropped, straight to IDLE
    op_valid = 1'b1; op_is_div = 1'b0; op_rd = 5'd8; op_dataA = 32'd1; op_dataB = 32'd1;
    #1;
    step();
    step();
    flush = 1'b1; md_resultRDY = 1'b1; md_result = 32'd77;
    step();
    flush = 1'b0; md_resultRDY = 1'b0; md_result = '0; op_valid = 1'b0;
    #1;
    check("flush_rdy_no_wb", 32'(wb_valid), 32'd0);
    check("flush_rdy_idle", 32'(busy), 32'd0);
    step();
    check("flush_rdy_no_wb_late", 32'(wb_valid), 32'd0);

    // asynchronous reset in the first BUSY cycle
    op_valid = 1'b1; op_is_div = 1'b1; op_rd = 5'd11; op_dataA = 32'd50; op_dataB = 32'd7;
    #1;
    step();
    check("pre_rst_div_pulse", 32'(md_ctrl_DIV), 32'd1);
    ctrl_reset = 1'b1;
    #1;
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_div", 32'(md_ctrl_DIV), 32'd0);
    check("async_rst_operandA", md_operandA, 32'd0);
    op_valid = 1'b0;
    #1;
    check("async_rst_stall", 32'(stall), 32'd0);
    step();
    ctrl_reset = 1'b0;
    md_resultRDY = 1'b1; md_result = 32'd7;
    step();
    md_resultRDY = 1'b0; md_result = '0;
    check("post_rst_no_wb", 32'(wb_valid), 32'd0);
    check("post_rst_idle", 32'(busy), 32'd0);
    step();

`ifdef MULTDIV_TIMEOUT_EN
    begin
      int waited;
      op_valid = 1'b1; op_is_div = 1'b0; op_rd = 5'd7; op_dataA = 32'd3; op_dataB = 32'd3;
      #1;
      step();
      waited = 1;
      while (!wb_valid && waited < 80) begin
        step();
        waited++;
      end
      check("timeout_cycle", 32'(waited), 32'd41);
      check("timeout_wb_valid", 32'(wb_valid), 32'd1);
      check("timeout_wb_rd", 32'(wb_rd), 32'd30);
      check("timeout_wb_data", wb_data, 32'd4);
      op_valid = 1'b0;
      step();
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
